// File: rtl/timer_tick_sequencer_if.sv
// timer_tick_sequencer_if
// Data-memory bus shared with the memory-mapped cycle timer.
//   address        : bus address           (initiator -> timer)
//   data           : write data            (initiator -> timer)
//   MemRead        : read strobe           (initiator -> timer)
//   MemWrite       : write strobe          (initiator -> timer)
//   rdata          : read data, combinational during a read (timer -> initiator)
//   TimerInterrupt : interrupt line        (timer -> initiator)
interface timer_tick_sequencer_if;
    logic [31:0] address;
    logic [31:0] data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] rdata;
    logic        TimerInterrupt;

    modport master (
        output address, data, MemRead, MemWrite,
        input  rdata, TimerInterrupt
    );

    modport slave (
        input  address, data, MemRead, MemWrite,
        output rdata, TimerInterrupt
    );
endinterface

// File: rtl/timer_tick_sequencer.sv
// timer_tick_sequencer
// Masters the timer's bus to produce a drift-free periodic tick: reads the
// cycle counter once, programs the interrupt cycle PERIOD ahead, then on each
// interrupt acknowledges it and re-arms PERIOD cycles after the previous
// target (the counter is never re-read while running).
// Ports:
//   clock      : single clock, rising edge
//   reset      : asynchronous, active-low
//   enable     : run request, sampled every cycle
//   bus        : timer bus (master side), see timer_tick_sequencer_if
//   tick       : one-cycle pulse per acknowledged interrupt
//   tick_count : ticks since reset, wraps mod 2^32
//   busy       : high in every state except IDLE
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | bus quiet, waiting for enable
// READ   | MemRead of TIMER_ADDR, target <= rdata + PERIOD
// ARM    | MemWrite of target to TIMER_ADDR
// WAIT   | bus quiet, waiting for TimerInterrupt (or enable drop)
// ACK    | MemWrite of 0 to ACK_ADDR, tick, target <= target + PERIOD
module timer_tick_sequencer #(
    parameter logic [31:0] PERIOD     = 32'd100,
    parameter logic [31:0] TIMER_ADDR = 32'hffff001c,
    parameter logic [31:0] ACK_ADDR   = 32'hffff006c
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    timer_tick_sequencer_if.master        bus,
    output logic                          tick,
    output logic [31:0]                   tick_count,
    output logic                          busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_ARM,
        S_WAIT,
        S_ACK
    } state_t;

    state_t      state;
    logic [31:0] target;
    logic [31:0] address_q;
    logic [31:0] data_q;
    logic        mem_read_q;
    logic        mem_write_q;

    logic [31:0] read_target;
    logic [31:0] next_target;

    assign read_target = bus.rdata + PERIOD;
    assign next_target = target + PERIOD;

    assign bus.address  = address_q;
    assign bus.data     = data_q;
    assign bus.MemRead  = mem_read_q;
    assign bus.MemWrite = mem_write_q;

    // Outputs are registered with the values belonging to the state being
    // entered, so they reflect the current state only and clear at once on
    // reset. ARM's write data is the freshly computed target.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            target      <= '0;
            tick_count  <= '0;
            tick        <= 1'b0;
            busy        <= 1'b0;
            address_q   <= '0;
            data_q      <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            address_q   <= '0;
            data_q      <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            tick        <= 1'b0;
            busy        <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state      <= S_READ;
                        address_q  <= TIMER_ADDR;
                        mem_read_q <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end

                S_READ: begin
                    target      <= read_target;
                    state       <= S_ARM;
                    address_q   <= TIMER_ADDR;
                    data_q      <= read_target;
                    mem_write_q <= 1'b1;
                end

                S_ARM: begin
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    // Disable wins over a coincident interrupt; the pending
                    // interrupt is deliberately left unacknowledged.
                    if (!enable) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (bus.TimerInterrupt) begin
                        state       <= S_ACK;
                        address_q   <= ACK_ADDR;
                        mem_write_q <= 1'b1;
                        tick        <= 1'b1;
                        tick_count  <= tick_count + 32'd1;
                    end
                end

                S_ACK: begin
                    // Re-arm relative to the previous target, not a new read,
                    // so the tick period never accumulates drift.
                    target <= next_target;
                    if (enable) begin
                        state       <= S_ARM;
                        address_q   <= TIMER_ADDR;
                        data_q      <= next_target;
                        mem_write_q <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
